// File: rtl/demux_rx_7bits_pkg.sv
// Shared defaults and encodings for the two-slot receive demultiplexer.
package demux_rx_7bits_pkg;

  localparam int unsigned P_W_DEF   = 7;
  localparam int unsigned P_CNT_DEF = 8;

  // Routing mode encodings
  localparam logic MODE_MANUAL = 1'b0;
  localparam logic MODE_ALT    = 1'b1;

  // Alternate-mode pointer states
  localparam logic PTR0 = 1'b0;
  localparam logic PTR1 = 1'b1;

endpackage

// File: rtl/demux_rx_7bits_slot.sv
// One output slot: a data register plus an EMPTY/FULL flag.
module demux_slot #(
  parameter int unsigned P_W = 7
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           load,
  input  logic [P_W-1:0] din,
  input  logic           ack,
  output logic [P_W-1:0] dout,
  output logic           valid
);

  // Load wins over ack so a simultaneous accept/ack leaves the slot FULL with new data
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dout  <= '0;
      valid <= 1'b0;
    end else if (load) begin
      dout  <= din;
      valid <= 1'b1;
    end else if (ack && valid) begin
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/demux_rx_7bits.sv
// Routes input words to one of two registered slots, manually or alternately.
module demux_rx_7bits
  import demux_rx_7bits_pkg::*;
#(
  parameter int unsigned P_W   = P_W_DEF,
  parameter int unsigned P_CNT = P_CNT_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [P_W-1:0]   ent,
  input  logic             ent_valid,
  output logic             ent_ready,
  input  logic             sel,
  input  logic             mode,
  output logic [P_W-1:0]   out0,
  output logic [P_W-1:0]   out1,
  output logic             out0_valid,
  output logic             out1_valid,
  input  logic             out0_ack,
  input  logic             out1_ack,
  output logic [P_CNT-1:0] cnt
);

  logic ptr;
  logic target;
  logic accept;
  logic load0;
  logic load1;

  // Target selection, backpressure and per-slot load strobes
  always_comb begin
    target    = (mode == MODE_ALT) ? ptr : sel;
    ent_ready = target ? (!out1_valid || out1_ack) : (!out0_valid || out0_ack);
    accept    = ent_valid && ent_ready;
    load0     = accept && !target;
    load1     = accept && target;
  end

  // Alternate-mode pointer flips only on accepts made in alternate mode
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr <= PTR0;
    end else if (accept && (mode == MODE_ALT)) begin
      ptr <= (ptr == PTR0) ? PTR1 : PTR0;
    end
  end

  // Accepted-word counter, wraps naturally at 2^P_CNT
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (accept) begin
      cnt <= cnt + P_CNT'(1);
    end
  end

  demux_slot #(.P_W(P_W)) u_slot0 (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (load0),
    .din   (ent),
    .ack   (out0_ack),
    .dout  (out0),
    .valid (out0_valid)
  );

  demux_slot #(.P_W(P_W)) u_slot1 (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (load1),
    .din   (ent),
    .ack   (out1_ack),
    .dout  (out1),
    .valid (out1_valid)
  );

endmodule

// File: tb/tb_demux_rx_7bits.sv
// Directed self-checking bench for demux_rx_7bits.
module tb_demux_rx_7bits;

  logic       clk;
  logic       rst_n;
  logic [6:0] ent;
  logic       ent_valid;
  logic       ent_ready;
  logic       sel;
  logic       mode;
  logic [6:0] out0;
  logic [6:0] out1;
  logic       out0_valid;
  logic       out1_valid;
  logic       out0_ack;
  logic       out1_ack;
  logic [7:0] cnt;

  int n_checks = 0;
  int n_fails  = 0;

  demux_rx_7bits #(.P_W(7), .P_CNT(8)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .ent        (ent),
    .ent_valid  (ent_valid),
    .ent_ready  (ent_ready),
    .sel        (sel),
    .mode       (mode),
    .out0       (out0),
    .out1       (out1),
    .out0_valid (out0_valid),
    .out1_valid (out1_valid),
    .out0_ack   (out0_ack),
    .out1_ack   (out1_ack),
    .cnt        (cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fails++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0; ent = '0; ent_valid = 1'b0; sel = 1'b0; mode = 1'b0;
    out0_ack = 1'b0; out1_ack = 1'b0;

    // Reset state
    #3;
    check("rst_out0", out0, 0);
    check("rst_out1", out1, 0);
    check("rst_v0", out0_valid, 0);
    check("rst_v1", out1_valid, 0);
    check("rst_ready", ent_ready, 1);
    check("rst_cnt", cnt, 0);
    tick();
    rst_n = 1'b1;

    // Manual routing to slot 1 on the first edge after reset release
    mode = 1'b0; sel = 1'b1; ent = 7'h55; ent_valid = 1'b1;
    tick();
    ent_valid = 1'b0;
    check("man_out1", out1, 7'h55);
    check("man_v1", out1_valid, 1);
    check("man_v0", out0_valid, 0);
    check("man_cnt", cnt, 1);
    out1_ack = 1'b1;
    tick();
    out1_ack = 1'b0;
    check("man_ack_v1", out1_valid, 0);

    // Backpressure on slot 0
    sel = 1'b0; ent = 7'h11; ent_valid = 1'b1;
    tick();
    ent = 7'h22;
    #1;
    check("bp_ready", ent_ready, 0);
    tick();
    check("bp_hold_out0", out0, 7'h11);
    check("bp_hold_v0", out0_valid, 1);
    check("bp_other_v1", out1_valid, 0);
    check("bp_cnt", cnt, 2);
    out0_ack = 1'b1;
    #1;
    check("bp_ack_ready", ent_ready, 1);
    tick();
    check("bp_new_out0", out0, 7'h22);
    check("bp_new_v0", out0_valid, 1);
    check("bp_new_cnt", cnt, 3);
    ent_valid = 1'b0;
    tick();
    out0_ack = 1'b0;
    check("bp_drain_v0", out0_valid, 0);

    // Asynchronous reset with both slots FULL
    sel = 1'b0; ent = 7'h0A; ent_valid = 1'b1;
    tick();
    sel = 1'b1; ent = 7'h0B;
    tick();
    check("pre_v0", out0_valid, 1);
    check("pre_v1", out1_valid, 1);
    check("pre_cnt", cnt, 5);
    ent_valid = 1'b1; sel = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_out0", out0, 0);
    check("arst_out1", out1, 0);
    check("arst_v0", out0_valid, 0);
    check("arst_v1", out1_valid, 0);
    check("arst_ready", ent_ready, 1);
    check("arst_cnt", cnt, 0);
    tick();
    check("arst_noacc_v0", out0_valid, 0);
    check("arst_noacc_cnt", cnt, 0);
    ent_valid = 1'b0;
    rst_n = 1'b1;

    // Alternate mode, acks held high
    mode = 1'b1; out0_ack = 1'b1; out1_ack = 1'b1; ent_valid = 1'b1; ent = 7'h01;
    tick();
    check("alt1_out0", out0, 7'h01);
    check("alt1_v0", out0_valid, 1);
    ent = 7'h02;
    tick();
    check("alt2_out1", out1, 7'h02);
    check("alt2_v1", out1_valid, 1);
    check("alt2_v0", out0_valid, 0);
    ent = 7'h03;
    tick();
    check("alt3_out0", out0, 7'h03);
    check("alt3_v0", out0_valid, 1);
    check("alt3_v1", out1_valid, 0);
    check("alt3_cnt", cnt, 3);
    check("alt3_ptr", dut.ptr, 1);
    ent_valid = 1'b0;
    tick();
    out0_ack = 1'b0; out1_ack = 1'b0;

    // Mode switch mid-stream
    rst_n = 1'b0;
    #1;
    check("sw_rst_ptr", dut.ptr, 0);
    rst_n = 1'b1;
    mode = 1'b1; ent = 7'h05; ent_valid = 1'b1;
    tick();
    check("sw1_out0", out0, 7'h05);
    check("sw1_ptr", dut.ptr, 1);
    mode = 1'b0; sel = 1'b0; ent = 7'h06; out0_ack = 1'b1;
    tick();
    check("sw2_out0", out0, 7'h06);
    check("sw2_v0", out0_valid, 1);
    check("sw2_v1", out1_valid, 0);
    check("sw2_ptr", dut.ptr, 1);
    check("sw2_cnt", cnt, 2);

    // Counter wrap: 256 more accepts into slot 0 with ack held
    ent = 7'h3C;
    for (int i = 0; i < 254; i++) tick();
    check("wrap_cnt0", cnt, 0);
    tick();
    tick();
    check("wrap_cnt2", cnt, 2);
    ent_valid = 1'b0;
    tick();
    out0_ack = 1'b0;
    check("wrap_v0", out0_valid, 0);

    // Spurious acks on empty slots change nothing
    out0_ack = 1'b1; out1_ack = 1'b1;
    tick();
    out0_ack = 1'b0; out1_ack = 1'b0;
    check("spur_v0", out0_valid, 0);
    check("spur_v1", out1_valid, 0);
    check("spur_out0", out0, 7'h3C);
    check("spur_cnt", cnt, 2);
    check("spur_ready", ent_ready, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule

// File: doc/demux_rx_7bits.md
DEMUX_RX_7BITS -- requirements
Module: demux_rx_7bits

Interface
REQ-001 SHALL provide parameter P_W, default 7, data width of the input word and of each output slot.
REQ-002 SHALL provide parameter P_CNT, default 8, width of the accepted-word counter.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port ent  input  P_W  input data word.
REQ-006 SHALL have port ent_valid  input  1  producer asserts that ent holds a word.
REQ-007 SHALL have port ent_ready  output  1  block can accept ent this cycle.
REQ-008 SHALL have port sel  input  1  target slot in manual mode (0 = slot 0, 1 = slot 1).
REQ-009 SHALL have port mode  input  1  0 = manual (target = sel), 1 = alternate (target = internal pointer).
REQ-010 SHALL have ports out0 and out1  output  P_W each  registered slot data.
REQ-011 SHALL have ports out0_valid and out1_valid  output  1 each  slot holds unconsumed data.
REQ-012 SHALL have ports out0_ack and out1_ack  input  1 each  consumer takes the slot data.
REQ-013 SHALL have port cnt  output  P_CNT  number of accepted words, modulo 2^P_CNT.

Function
REQ-014 SHALL define target = sel when mode = 0, and target = ptr when mode = 1.
REQ-015 SHALL drive ent_ready combinationally as (NOT outT_valid) OR outT_ack, where T = target.
REQ-016 SHALL accept a word when ent_valid AND ent_ready; only the target slot is written.
REQ-017 SHALL hold each slot in one of two states, EMPTY or FULL: EMPTY->FULL on accept; FULL->EMPTY on ack without accept; FULL->FULL with the new data on simultaneous accept and ack.
REQ-018 SHALL give one-cycle latency: a word accepted at edge N appears on outT with outT_valid = 1 immediately after edge N.
REQ-019 SHALL hold outX stable while outX_valid = 1 and no new accept targets slot X.
REQ-020 SHALL ignore outX_ack when outX_valid = 0.
REQ-021 SHALL let acks on both slots in the same cycle each take effect independently.
REQ-022 SHALL toggle the pointer ptr (state PTR0/PTR1) on each accept made while mode = 1, and leave it unchanged while mode = 0.
REQ-023 SHALL take target from the current-cycle mode and ptr values when mode changes mid-stream; no word is lost or duplicated.
REQ-024 SHALL leave a non-target slot unaffected (data and valid) when the target slot is FULL and blocked.
REQ-025 SHALL increment cnt by 1 per accept, wrapping from 2^P_CNT-1 to 0.

Reset
REQ-026 SHALL, on rst_n = 0 and regardless of clk, force out0 = 0, out1 = 0, out0_valid = 0, out1_valid = 0, ptr = PTR0 and cnt = 0.
REQ-027 SHALL discard any in-flight data when reset asserts mid-operation; no accept occurs while rst_n = 0.
REQ-028 SHALL drive ent_ready = 1 while in reset, because both slots are EMPTY.
REQ-029 SHALL be able to accept at the first rising edge after rst_n deasserts.

Structure
REQ-030 SHALL place the defaults of P_W and P_CNT, and the mode encodings MODE_MANUAL = 0 and MODE_ALT = 1, in a shared package.
REQ-031 SHALL implement each slot as one instance of sub-module demux_slot, with ports clk, rst_n, load, din, ack, dout and valid, instantiated twice.
REQ-032 SHALL keep the pointer, the target select and the counter in the top module; no latches and no combinational loops.

Verification
REQ-033 Reset: rst_n = 0 mid-stream with both slots FULL -> all outputs 0, ent_ready = 1, cnt = 0, immediately and asynchronously.
REQ-034 Manual routing: mode = 0, sel = 1, ent = 7'h55, ent_valid for one cycle -> out1 = 7'h55 and out1_valid = 1 next cycle; out0_valid = 0; cnt = 1.
REQ-035 Backpressure: slot 0 FULL with 7'h11, no ack, sel = 0, ent = 7'h22 valid -> ent_ready = 0 and out0 stays 7'h11; assert out0_ack -> same-cycle accept, out0 = 7'h22, out0_valid stays 1.
REQ-036 Alternate mode: mode = 1 from reset; words 7'h01, 7'h02, 7'h03 accepted back-to-back while both acks are held at 1 -> word 1 goes to slot 0, word 2 to slot 1, word 3 to slot 0; ptr ends at PTR1.
REQ-037 Mode switch mid-stream: accept one word with mode = 1 (ptr becomes PTR1), then accept with mode = 0 and sel = 0 -> word goes to slot 0 and ptr stays PTR1.
REQ-038 Counter wrap: 256 accepts with P_CNT = 8 -> cnt returns to 0; a spurious ack on an EMPTY slot -> no state change.
